// File: rtl/cla_seq_pkg.sv
// Shared constants and types for the multi-word CLA sequencer.
package cla_seq_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // A one-slice configuration still needs a 1-bit index register.
  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/CLA_16_bit_lookahead.sv
// 16-bit carry-lookahead adder: four 4-bit groups with a second-level
// lookahead unit generating the group carries.
module CLA_16_bit_lookahead (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;
  logic [15:0] c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
    end
  end

  // Group carries are flat sum-of-products of cin, so depth does not grow per group.
  assign gc[0] = cin;
  assign gc[1] = gg[0] | (gp[0] & cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cin);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
  end

  assign sum  = p ^ c;
  assign cout = gc[4];

endmodule

// File: rtl/cla_multiword_sequencer.sv
// Wide add/subtract built by stepping one 16-bit CLA slice across the operand,
// least-significant slice first, with a registered inter-slice carry.
module cla_multiword_sequencer
  import cla_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SLICE_W*WORDS-1:0]   a,
  input  logic [SLICE_W*WORDS-1:0]   b,
  input  logic                       cin,
  input  logic                       sub,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SLICE_W*WORDS-1:0]   sum,
  output logic                       cout,
  output logic                       ovf,
  output state_t                     dbg_state
);

  localparam int W     = SLICE_W * WORDS;
  localparam int IDX_W = idx_w(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready/out_valid depend only on state, never on inputs.
  state_t           state;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic [W-1:0]     sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;

  CLA_16_bit_lookahead u_cla (
    .a    (a_q[SLICE_W-1:0]),
    .b    (b_q[SLICE_W-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            idx_q   <= '0;
            sum_q   <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          // Operands shift down so the active slice always sits in the low bits.
          sum_q[idx_q*SLICE_W +: SLICE_W] <= slice_sum;
          carry_q <= slice_cout;
          a_q     <= a_q >> SLICE_W;
          b_q     <= b_q >> SLICE_W;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            cout_q <= slice_cout;
            ovf_q  <= (a_q[SLICE_W-1] == b_q[SLICE_W-1]) &&
                      (slice_sum[SLICE_W-1] != a_q[SLICE_W-1]);
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_cla_multiword_sequencer.sv
// Directed bench for cla_multiword_sequencer at the default WORDS=4.
module tb_cla_multiword_sequencer;
  import cla_seq_pkg::*;

  localparam int W = 64;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  state_t       dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  cla_multiword_sequencer #(.WORDS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits for out_valid, sampling 1 time unit after each edge; returns edge count.
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci, input logic sb, input logic [W-1:0] es,
                        input logic ec, input logic eo);
    int cnt;
    @(negedge clk);
    a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++; $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
    wait_done(cnt);
    n_checks++;
    if (cnt !== 4) begin
      n_errors++; $display("FAIL %s latency: got %0d want 4", name, cnt);
    end
    n_checks++;
    if (sum !== es) begin
      n_errors++; $display("FAIL %s sum: got %h want %h", name, sum, es);
    end
    n_checks++;
    if (cout !== ec) begin
      n_errors++; $display("FAIL %s cout: got %b want %b", name, cout, ec);
    end
    n_checks++;
    if (ovf !== eo) begin
      n_errors++; $display("FAIL %s ovf: got %b want %b", name, ovf, eo);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++; $display("FAIL %s drain: got out_valid=%b in_ready=%b want 0/1",
                           name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 ||
        ovf !== 1'b0 || dbg_state !== S_IDLE) begin
      n_errors++;
      $display("FAIL reset: got rdy=%b vld=%b sum=%h cout=%b ovf=%b st=%0d want 1 0 0 0 0 0",
               in_ready, out_valid, sum, cout, ovf, dbg_state);
    end
  endtask

  task automatic test_add();
    run_op("add", 64'h0000_0000_0000_FF3F, 64'h0000_0000_0000_5555, 1'b0, 1'b0,
           64'h0000_0000_0001_5494, 1'b0, 1'b0);
    run_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
    run_op("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 1'b1);
  endtask

  task automatic test_sub();
    run_op("sub_neg", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_pos", 64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0);
    // cin must be ignored while subtracting
    run_op("sub_cin", 64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1, 1'b0);
    run_op("ovf_sub", 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
  endtask

  task automatic test_backpressure();
    int cnt;
    @(negedge clk);
    a = 64'h1000; b = 64'h0234; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    wait_done(cnt);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = {$urandom, $urandom}; in_valid = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 64'h1234 ||
          cout !== 1'b0 || ovf !== 1'b0) begin
        n_errors++;
        $display("FAIL hold cycle %0d: got vld=%b rdy=%b sum=%h cout=%b ovf=%b want 1 0 1234 0 0",
                 i, out_valid, in_ready, sum, cout, ovf);
      end
    end
    @(negedge clk);
    a = 64'h10; b = 64'h20; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++; $display("FAIL release: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1; in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0 || sum !== '0 || dbg_state !== S_RUN) begin
      n_errors++; $display("FAIL pending accept: got rdy=%b sum=%h st=%0d want 0 0 1",
                           in_ready, sum, dbg_state);
    end
    wait_done(cnt);
    n_checks++;
    if (cnt !== 4 || sum !== 64'h30) begin
      n_errors++; $display("FAIL pending result: got lat=%0d sum=%h want 4 30", cnt, sum);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int seen;
    @(negedge clk);
    a = 64'h0000_0000_0000_FF3F; b = 64'h0000_0000_0000_5555; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if (sum !== 64'h0000_0000_0001_5494 || out_valid !== 1'b0) begin
      n_errors++; $display("FAIL partial sum: got sum=%h vld=%b want 15494 0", sum, out_valid);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 ||
        ovf !== 1'b0) begin
      n_errors++; $display("FAIL mid reset: got rdy=%b vld=%b sum=%h cout=%b ovf=%b want 1 0 0 0 0",
                           in_ready, out_valid, sum, cout, ovf);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_errors++; $display("FAIL discarded op: got %0d out_valid cycles want 0", seen);
    end
    run_op("after_reset", 64'h0000_0000_0000_FF3F, 64'h0000_0000_0000_5555, 1'b0, 1'b0,
           64'h0000_0000_0001_5494, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
